// File: rtl/com_tx_responder.sv
// Communication responder: on a rising edge of the sticky COM flag, reads NUM_WORDS words
// from data memory and sends each as four MSB-first UART bytes. Define COM_TX_PARITY_EN for 8E1 frames.
module com_tx_responder #(
   parameter int          CLKS_PER_BIT = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          NUM_WORDS    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        com_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        tx,
   output logic        busy,
   output logic        com_done,
   output logic [2:0]  dbg_state
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_STOP   = 3'd5,
`ifdef COM_TX_PARITY_EN
      S_PARITY = 3'd7,
`endif
      S_DONE   = 3'd6
   } state_t;

   state_t          state;
   logic            req_q;
   logic [31:0]     shreg;
   logic [1:0]      byte_cnt;
   logic [2:0]      bit_cnt;
   logic [BW-1:0]   baud;
   logic [WW-1:0]   word_cnt;
   logic [7:0]      cur_byte;
   logic            baud_end;
   logic            trigger;

   assign dbg_state = state;
   assign baud_end  = (baud == BW'(CLKS_PER_BIT - 1));
   assign trigger   = com_req & ~req_q;

   // Bytes leave most-significant first, selected from the latched word.
   always_comb begin
      cur_byte = shreg[31:24];
      case (byte_cnt)
         2'd0: cur_byte = shreg[31:24];
         2'd1: cur_byte = shreg[23:16];
         2'd2: cur_byte = shreg[15:8];
         2'd3: cur_byte = shreg[7:0];
         default: cur_byte = shreg[31:24];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         req_q    <= 1'b0;
         shreg    <= '0;
         byte_cnt <= '0;
         bit_cnt  <= '0;
         baud     <= '0;
         word_cnt <= '0;
         mem_addr <= BASE_ADDR;
         tx       <= 1'b1;
         busy     <= 1'b0;
         com_done <= 1'b0;
      end else begin
         req_q <= com_req;
         case (state)
            S_IDLE: begin
               com_done <= 1'b0;
               if (trigger) begin
                  mem_addr <= BASE_ADDR;
                  word_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= S_FETCH;
               end
            end

            S_FETCH: state <= S_LOAD;

            S_LOAD: begin
               shreg    <= mem_rdata;
               byte_cnt <= '0;
               baud     <= '0;
               tx       <= 1'b0;
               state    <= S_START;
            end

            S_START: begin
               if (baud_end) begin
                  baud    <= '0;
                  bit_cnt <= '0;
                  tx      <= cur_byte[0];
                  state   <= S_DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            S_DATA: begin
               if (baud_end) begin
                  baud <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef COM_TX_PARITY_EN
                     tx    <= ^cur_byte;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= cur_byte[bit_cnt + 3'd1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end

`ifdef COM_TX_PARITY_EN
            S_PARITY: begin
               if (baud_end) begin
                  baud  <= '0;
                  tx    <= 1'b1;
                  state <= S_STOP;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (baud_end) begin
                  baud <= '0;
                  if (byte_cnt != 2'd3) begin
                     byte_cnt <= byte_cnt + 2'd1;
                     tx       <= 1'b0;
                     state    <= S_START;
                  end else if (word_cnt != WW'(NUM_WORDS - 1)) begin
                     // Line stays idle high through FETCH/LOAD of the next word.
                     word_cnt <= word_cnt + 1'b1;
                     mem_addr <= mem_addr + 32'd4;
                     state    <= S_FETCH;
                  end else begin
                     com_done <= 1'b1;
                     busy     <= 1'b0;
                     state    <= S_DONE;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            S_DONE: begin
               com_done <= 1'b0;
               state    <= S_IDLE;
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/com_tx_responder.md
# com_tx_responder

Serves the CPU's communication request. On a rising edge of the sticky COM flag, it reads `NUM_WORDS` 32-bit words from data memory starting at `BASE_ADDR`. It serialises each word as four UART 8N1 byte frames to the interpreter, then returns a one-cycle completion pulse. It sits between the pipeline's control unit (COM flag source), the data-memory read port, and the off-chip serial line.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥2.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word read.
- `NUM_WORDS`, 4: words sent per request; legal range ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `com_req`  in  1  COM flag from the CPU, level and sticky; only its rising edge starts a transfer.
- `mem_addr`  out  32  data-memory read byte address, registered.
- `mem_rdata`  in  32  read data, valid one cycle after `mem_addr` is presented (synchronous read).
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high while a transfer is in progress.
- `com_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `com_done`=0, `mem_addr`=`BASE_ADDR`, state IDLE, `req_q`=0, word/byte/bit/baud counters=0.
- Edge detect: `req_q` registers `com_req` every cycle. A trigger is `com_req & ~req_q` sampled in IDLE; edges seen outside IDLE are ignored, not queued.
- IDLE → FETCH on trigger: `mem_addr`<=`BASE_ADDR`, word_cnt<=0, `busy`<=1.
- FETCH → LOAD: address held for memory.
- LOAD → START: `shreg`<=`mem_rdata`, byte_cnt<=0.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: sends the current byte LSB first, `CLKS_PER_BIT` cycles per bit, 8 bits, then PARITY (when compiled in) or STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
- At the end of STOP:
  - If byte_cnt<3: byte_cnt++ and go to START.
  - Else if word_cnt<`NUM_WORDS`-1: word_cnt++, `mem_addr`<=`mem_addr`+4, go to FETCH.
  - Else: go to DONE.
- Byte order within a word: most-significant byte first (bits 31:24, 23:16, 15:8, 7:0).
- DONE: `com_done`=1 for exactly one cycle, `busy`<=0, return to IDLE.
- Address arithmetic is 32-bit modulo 2^32. Wrap past 32'hFFFF_FFFC is allowed and not flagged.
- `reset` asserted mid-frame: the next edge aborts immediately. All outputs take their reset values (`tx` returns high, even mid start bit), and no `com_done` is produced.
- `com_req` still high after reset: `req_q`=0, so one new transfer is triggered on the first post-reset cycle.

## Timing
- Trigger sampled at edge k: FETCH at k, LOAD at k+1, start bit on `tx` from edge k+2.
- Byte frame length: 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- Bytes within a word are back-to-back, with no idle cycles.
- Between words: exactly 2 idle cycles (`tx`=1) for FETCH/LOAD.
- Full transfer: edge of trigger to `com_done` = 2·`NUM_WORDS` + 4·`NUM_WORDS`·F cycles, where F is the frame length; `com_done` is asserted the cycle after the last stop bit ends.
- `busy` rises at edge k, falls with `com_done`. A new trigger is accepted no earlier than the cycle after `com_done`.

## Configuration
- `COM_TX_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP, lasting `CLKS_PER_BIT` cycles. Frames become 11 bits.
- `COM_TX_PARITY_EN` undefined: no PARITY state, plain 8N1.

## Test plan
- Reset with `com_req`=0 → `tx`=1, `busy`=0, `com_done`=0, `mem_addr`=0, held for 100 cycles.
- `CLKS_PER_BIT`=4, `NUM_WORDS`=1, word 32'hA5C3_0F81 → bytes A5, C3, 0F, 81, each LSB first.
  - First start bit at trigger edge +2.
  - `com_done` at trigger+2+160.
- `NUM_WORDS`=3, `BASE_ADDR`=32'h100 → `mem_addr` sequence 100, 104, 108, with 2 idle cycles between words and one `com_done` pulse.
- `com_req` held high for 5000 cycles → exactly one transfer and one `com_done`.
  - Drop, then re-raise after `com_done` → a second transfer.
- `reset` pulsed mid data bit of byte 2 with `com_req` still high → `tx`=1 next cycle, no `com_done`.
  - A fresh transfer then starts and `mem_addr` restarts at `BASE_ADDR`.
- With `COM_TX_PARITY_EN`, byte 8'h07 → parity bit 1; byte 8'h03 → parity bit 0; frame length 44 cycles at `CLKS_PER_BIT`=4.
